// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter.
//   arb_state_t      : FSM state encoding (IDLE / ACCESS / RESP)
//   ARB_DEFAULT_LAT  : default bus access latency in cycles
package data_bus_arbiter_pkg;

  localparam int unsigned ARB_DEFAULT_LAT = 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req0, req1 : request lines
//   last       : index of the most recent grant
//   valid      : at least one request present
//   winner     : granted index; on a tie the index that did not win last time
module data_bus_arbiter_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  // A lone requester wins outright; with no request the value is don't-care (0).
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter sharing the CPU-side data port of the bus bridge between
// the CPU M stage (M0) and a DMA/copy engine (M1).
// Ports:
//   clk, reset                : clock (rising edge), asynchronous active-high reset
//   m0_* / m1_*               : master request, address, write data, byte enables
//                               (0000 = read), read data and one-cycle done pulse
//   bus_addr/wdata/byteen     : access to the bridge (0 when not in ACCESS)
//   bus_rdata                 : read data from the bridge
//   cpu_stall                 : freeze the CPU pipeline while M0 waits
//   busy                      : arbiter not IDLE
// Parameters:
//   LAT   : bus access cycles per transaction (1..15)
//   CNT_W : latency counter width, 2**CNT_W > LAT
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned LAT   = ARB_DEFAULT_LAT,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata,
  output logic        cpu_stall,
  output logic        busy
);

  // Counter load value; the first ACCESS cycle is recognised by cnt == CNT_INIT.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  arb_state_t       state_reg, state_next;
  logic             owner_reg;
  logic             last_grant_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       byteen_reg;
  logic [31:0]      rdata_reg;

  logic             pick_valid;
  logic             pick_winner;

  data_bus_arbiter_rr_pick2 u_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (last_grant_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs; nothing here depends on m*_req
  // except the IDLE transition, so bus outputs never see a request directly.
  always_comb begin
    state_next = state_reg;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_byteen = '0;
    m0_done    = 1'b0;
    m1_done    = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) state_next = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        bus_addr  = addr_reg;
        bus_wdata = wdata_reg;
        // Single write strobe per transaction regardless of LAT.
        if (cnt_reg == CNT_INIT) bus_byteen = byteen_reg;
        if (cnt_reg == '0) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        state_next = ARB_IDLE;
        if (owner_reg) begin
          m1_done  = 1'b1;
          m1_rdata = rdata_reg;
        end else begin
          m0_done  = 1'b1;
          m0_rdata = rdata_reg;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Grant bookkeeping, payload latches, latency counter and read capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;   // M0 wins the first tie after reset
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      byteen_reg     <= '0;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner_reg      <= pick_winner;
            last_grant_reg <= pick_winner;
            cnt_reg        <= CNT_INIT;
            addr_reg       <= pick_winner ? m1_addr   : m0_addr;
            wdata_reg      <= pick_winner ? m1_wdata  : m0_wdata;
            byteen_reg     <= pick_winner ? m1_byteen : m0_byteen;
          end
        end
        ARB_ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            // Captured for writes too; the master simply ignores it.
            rdata_reg <= bus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_stall = m0_req & ~m0_done;
  assign busy      = (state_reg != ARB_IDLE);

endmodule
